// File: rtl/a51_search_ctrl_if.sv
// Host/pipeline/result bundle for the A5/1 candidate search controller.
// master = host plus keystream pipeline side, slave = controller.
interface a51_search_ctrl_if #(
    parameter int unsigned StateWidth = 64
);
    logic                  start;
    logic                  abort;
    logic [StateWidth-1:0] base_state;
    logic [31:0]           count;
    logic [StateWidth-1:0] target;
    logic [StateWidth-1:0] mask;
    logic                  pl_enable;
    logic [StateWidth-1:0] pl_state;
    logic [StateWidth-1:0] pl_keystream;
    logic                  match_valid;
    logic                  match_ready;
    logic [StateWidth-1:0] match_state;
    logic                  busy;
    logic                  done;
    logic [31:0]           hits;

    modport master (
        output start, abort, base_state, count, target, mask, pl_keystream, match_ready,
        input  pl_enable, pl_state, match_valid, match_state, busy, done, hits
    );

    modport slave (
        input  start, abort, base_state, count, target, mask, pl_keystream, match_ready,
        output pl_enable, pl_state, match_valid, match_state, busy, done, hits
    );
endinterface

// File: rtl/a51_search_ctrl.sv
// Issues consecutive candidate states into a fixed-latency keystream pipeline and
// reports candidates whose masked keystream equals the target.
module a51_search_ctrl #(
    parameter int unsigned StateWidth = 64,
    parameter int unsigned Latency    = 100
) (
    input logic                clk,
    input logic                rst_n,
    a51_search_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                state_q, state_d;
    logic [StateWidth-1:0] base_q, base_d;
    logic [StateWidth-1:0] target_q, target_d;
    logic [StateWidth-1:0] mask_q, mask_d;
    logic [StateWidth-1:0] match_state_q, match_state_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           issue_idx_q, issue_idx_d;
    logic [31:0]           retire_idx_q, retire_idx_d;
    logic [31:0]           hits_q, hits_d;
    logic [Latency-1:0]    tag_q, tag_d;
    logic                  match_valid_q, match_valid_d;
    logic                  done_q, done_d;

    logic pl_enable;
    logic issue_valid;
    logic retire;
    logic hit;

    // Everything that tracks the pipeline freezes while a match waits for its consumer.
    always_comb begin
        pl_enable   = (state_q != StIdle) && !(match_valid_q && !bus.match_ready);
        issue_valid = (state_q == StRun);
        retire      = pl_enable && tag_q[Latency-1];
        hit         = retire && (((bus.pl_keystream ^ target_q) & mask_q) == '0);
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        target_d      = target_q;
        mask_d        = mask_q;
        match_state_d = match_state_q;
        count_d       = count_q;
        issue_idx_d   = issue_idx_q;
        retire_idx_d  = retire_idx_q;
        hits_d        = hits_q;
        tag_d         = tag_q;
        match_valid_d = match_valid_q;
        done_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    base_d       = bus.base_state;
                    count_d      = bus.count;
                    target_d     = bus.target;
                    mask_d       = bus.mask;
                    issue_idx_d  = '0;
                    retire_idx_d = '0;
                    hits_d       = '0;
                    if (bus.count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun, StDrain: begin
                if (pl_enable) begin
                    tag_d = {tag_q[Latency-2:0], issue_valid};
                    if (state_q == StRun) begin
                        issue_idx_d = issue_idx_q + 32'd1;
                        if (issue_idx_q == count_q - 32'd1) begin
                            state_d = StDrain;
                        end
                    end
                    if (retire) begin
                        retire_idx_d = retire_idx_q + 32'd1;
                    end
                end
                // A fresh hit overrides the consume-clear of the previous one.
                if (hit) begin
                    match_valid_d = 1'b1;
                    match_state_d = base_q + StateWidth'(retire_idx_q);
                    if (hits_q != '1) begin
                        hits_d = hits_q + 32'd1;
                    end
                end else if (match_valid_q && bus.match_ready) begin
                    match_valid_d = 1'b0;
                end
                if (state_q == StDrain && retire_idx_q == count_q && !match_valid_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
                if (bus.abort) begin
                    state_d       = StIdle;
                    tag_d         = '0;
                    match_valid_d = 1'b0;
                    issue_idx_d   = '0;
                    retire_idx_d  = '0;
                    done_d        = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            base_q        <= '0;
            target_q      <= '0;
            mask_q        <= '0;
            match_state_q <= '0;
            count_q       <= '0;
            issue_idx_q   <= '0;
            retire_idx_q  <= '0;
            hits_q        <= '0;
            tag_q         <= '0;
            match_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            target_q      <= target_d;
            mask_q        <= mask_d;
            match_state_q <= match_state_d;
            count_q       <= count_d;
            issue_idx_q   <= issue_idx_d;
            retire_idx_q  <= retire_idx_d;
            hits_q        <= hits_d;
            tag_q         <= tag_d;
            match_valid_q <= match_valid_d;
            done_q        <= done_d;
        end
    end

    assign bus.pl_enable   = pl_enable;
    assign bus.pl_state    = (state_q == StRun) ? base_q + StateWidth'(issue_idx_q) : '0;
    assign bus.match_valid = match_valid_q;
    assign bus.match_state = match_state_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.hits        = hits_q;
endmodule

// File: tb/tb_a51_search_ctrl.sv
// Directed bench for a51_search_ctrl: job table plus abort, reset and start/abort corner cases.
module tb_a51_search_ctrl;
    localparam int unsigned SW  = 64;
    localparam int unsigned LAT = 100;
    localparam logic [63:0] K   = 64'hC3A5_0F1E_9B7D_2468;

    typedef struct {
        logic [63:0] base;
        logic [31:0] count;
        logic [63:0] target;
        logic [63:0] mask;
        int          stall;
        bit          poke;
        int          exp_hits;
        logic [63:0] exp_first;
        logic [63:0] exp_last;
        int          exp_step;
        int          exp_first_cyc;
        int          exp_done_cyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    a51_search_ctrl_if #(.StateWidth(SW)) ifc ();

    a51_search_ctrl #(.StateWidth(SW), .Latency(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    // Keystream pipeline model: keystream(s) = s ^ K after LAT enabled cycles.
    logic [63:0] pipe [LAT];
    always @(posedge clk) begin
        if (ifc.pl_enable) begin
            pipe[0] <= ifc.pl_state ^ K;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign ifc.pl_keystream = pipe[LAT-1];

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] got [$];
    int          first_cyc, done_cyc, done_cnt;
    bit          busy_seen;
    vec_t        vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_start(input vec_t v, input bit ab);
        ifc.start      = 1'b1;
        ifc.abort      = ab;
        ifc.base_state = v.base;
        ifc.count      = v.count;
        ifc.target     = v.target;
        ifc.mask       = v.mask;
    endtask

    task automatic do_vec(input vec_t v, input bit ab, input string tag);
        int          stall_rem;
        int          max_cyc;
        logic [63:0] held;
        bit          order_ok;
        got.delete();
        first_cyc = -1;
        done_cyc  = -1;
        done_cnt  = 0;
        busy_seen = 1'b0;
        stall_rem = v.stall;
        held      = '0;
        max_cyc   = int'(v.count) + LAT + v.stall + 40;
        drive_start(v, ab);
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(posedge clk);
            #1;
            ifc.start = 1'b0;
            ifc.abort = 1'b0;
            if (v.poke && cyc == 10) begin
                ifc.start      = 1'b1;
                ifc.base_state = 64'hDEAD_0000_0000_0000;
                ifc.count      = 32'd1;
            end
            if (ifc.busy) busy_seen = 1'b1;
            if (ifc.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (ifc.match_valid && first_cyc < 0) first_cyc = cyc;
            if (ifc.match_valid && !ifc.match_ready) begin
                chk($sformatf("%s.stall_enable", tag), {63'd0, ifc.pl_enable}, 64'd0);
                chk($sformatf("%s.stall_state", tag), ifc.match_state, held);
            end
            if (ifc.match_valid && stall_rem > 0) begin
                if (stall_rem == v.stall) held = ifc.match_state;
                ifc.match_ready = 1'b0;
                stall_rem--;
            end else begin
                ifc.match_ready = 1'b1;
            end
            if (ifc.match_valid && ifc.match_ready) got.push_back(ifc.match_state);
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        chk($sformatf("%s.matches", tag), 64'(got.size()), 64'(v.exp_hits));
        chk($sformatf("%s.hits", tag), {32'd0, ifc.hits}, 64'(v.exp_hits));
        chk($sformatf("%s.done_cyc", tag), 64'(done_cyc), 64'(v.exp_done_cyc));
        chk($sformatf("%s.done_cnt", tag), 64'(done_cnt), 64'd1);
        chk($sformatf("%s.busy_seen", tag), {63'd0, busy_seen}, {63'd0, v.count != 0});
        if (v.exp_hits > 0 && got.size() > 0) begin
            chk($sformatf("%s.first", tag), got[0], v.exp_first);
            chk($sformatf("%s.last", tag), got[got.size()-1], v.exp_last);
            chk($sformatf("%s.first_cyc", tag), 64'(first_cyc), 64'(v.exp_first_cyc));
        end
        if (v.exp_step != 0) begin
            order_ok = 1'b1;
            for (int i = 1; i < got.size(); i++) begin
                if (got[i] != got[i-1] + 64'(v.exp_step)) order_ok = 1'b0;
            end
            chk($sformatf("%s.order", tag), {63'd0, order_ok}, 64'd1);
        end
    endtask

    initial begin
        int mv_cnt;
        int dn_cnt;
        vecs[0] = '{64'h10, 32'd4, 64'h0, 64'h0, 0, 1'b0, 4, 64'h10, 64'h13, 1, 101, 106};
        vecs[1] = '{64'h0000_1234_0000_0000, 32'd200, (64'h0000_1234_0000_0000 + 64'd150) ^ K,
                    '1, 0, 1'b0, 1, 64'h0000_1234_0000_0096, 64'h0000_1234_0000_0096, 0, 251, 301};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFE, 32'd3, 64'h0, 64'h0, 0, 1'b0, 3,
                    64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1, 101, 105};
        vecs[3] = '{64'h100, 32'd16, 64'h100 ^ K, 64'h1, 0, 1'b1, 8, 64'h100, 64'h10E, 2, 101, 117};
        vecs[4] = '{64'h2000, 32'd8, 64'h0, 64'h0, 20, 1'b0, 8, 64'h2000, 64'h2007, 1, 101, 130};
        vecs[5] = '{64'h55, 32'd0, 64'h0, 64'h0, 0, 1'b0, 0, 64'h0, 64'h0, 0, -1, 0};

        ifc.start       = 1'b0;
        ifc.abort       = 1'b0;
        ifc.base_state  = '0;
        ifc.count       = '0;
        ifc.target      = '0;
        ifc.mask        = '0;
        ifc.match_ready = 1'b1;
        rst_n           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", {63'd0, ifc.busy}, 64'd0);
        chk("reset.done", {63'd0, ifc.done}, 64'd0);
        chk("reset.pl_enable", {63'd0, ifc.pl_enable}, 64'd0);
        chk("reset.pl_state", ifc.pl_state, 64'd0);
        chk("reset.match_valid", {63'd0, ifc.match_valid}, 64'd0);
        chk("reset.hits", {32'd0, ifc.hits}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) do_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Abort in DRAIN: no done, no stale matches, then a clean job with abort+start.
        drive_start('{64'h3000, 32'd5, 64'h0, 64'h0, 0, 1'b0, 5, 64'h3000, 64'h3004, 1, 101, 107},
                    1'b0);
        for (int cyc = 0; cyc <= 50; cyc++) begin
            @(posedge clk);
            #1;
            ifc.start = 1'b0;
        end
        chk("abort.busy_before", {63'd0, ifc.busy}, 64'd1);
        ifc.abort = 1'b1;
        @(posedge clk);
        #1;
        ifc.abort = 1'b0;
        chk("abort.busy_after", {63'd0, ifc.busy}, 64'd0);
        chk("abort.pl_enable", {63'd0, ifc.pl_enable}, 64'd0);
        mv_cnt = 0;
        dn_cnt = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (ifc.match_valid) mv_cnt++;
            if (ifc.done) dn_cnt++;
            @(posedge clk);
            #1;
        end
        chk("abort.stale_matches", 64'(mv_cnt), 64'd0);
        chk("abort.done_pulses", 64'(dn_cnt), 64'd0);
        do_vec(vecs[0], 1'b1, "after_abort");

        // Reset mid-RUN.
        drive_start('{64'h4000, 32'd200, 64'h0, 64'h0, 0, 1'b0, 0, 64'h0, 64'h0, 0, 0, 0}, 1'b0);
        for (int cyc = 0; cyc <= 120; cyc++) begin
            @(posedge clk);
            #1;
            ifc.start = 1'b0;
        end
        chk("rst_mid.hits_before", {32'd0, ifc.hits}, 64'd20);
        chk("rst_mid.state_before", ifc.match_state, 64'h4013);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid.busy", {63'd0, ifc.busy}, 64'd0);
        chk("rst_mid.pl_enable", {63'd0, ifc.pl_enable}, 64'd0);
        chk("rst_mid.pl_state", ifc.pl_state, 64'd0);
        chk("rst_mid.match_valid", {63'd0, ifc.match_valid}, 64'd0);
        chk("rst_mid.match_state", ifc.match_state, 64'd0);
        chk("rst_mid.hits", {32'd0, ifc.hits}, 64'd0);
        chk("rst_mid.done", {63'd0, ifc.done}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_vec(vecs[0], 1'b0, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/a51_search_ctrl.md
A51_SEARCH_CTRL -- requirements
Module: a51_search_ctrl

Interface
REQ-001 Parameter: StateWidth, 64, width of the candidate state and the keystream word.
REQ-002 Parameter: Latency, 100, number of enabled clock cycles from pl_state to the matching pl_keystream.
REQ-003 Port: clk  in  1  sole clock; all logic is on the rising edge.
REQ-004 Port: rst_n  in  1  reset, synchronous and active-low.
REQ-005 Port: start  in  1  one-cycle job launch; sampled only in IDLE.
REQ-006 Port: abort  in  1  one-cycle job cancel.
REQ-007 Port: base_state  in  StateWidth  first candidate; captured on an accepted start.
REQ-008 Port: count  in  32  number of candidates in the job; captured on an accepted start.
REQ-009 Port: target  in  StateWidth  reference keystream; captured on an accepted start.
REQ-010 Port: mask  in  StateWidth  compare mask, 1 = bit compared; captured on an accepted start.
REQ-011 Port: pl_enable  out  1  enable for the keystream pipeline.
REQ-012 Port: pl_state  out  StateWidth  candidate state driven into the pipeline.
REQ-013 Port: pl_keystream  in  StateWidth  pipeline output.
REQ-014 Port: match_valid  out  1  a match is held on match_state.
REQ-015 Port: match_ready  in  1  consumer accepts the held match.
REQ-016 Port: match_state  out  StateWidth  candidate that produced the match.
REQ-017 Port: busy  out  1  job in progress (state RUN or DRAIN).
REQ-018 Port: done  out  1  one-cycle pulse at job end.
REQ-019 Port: hits  out  32  number of matches found in the current or last job.

Function
REQ-020 FSM states: IDLE, RUN, DRAIN; the FSM SHALL start in IDLE.
REQ-021 IDLE + start: capture base_state, count, target and mask; clear issue_idx, retire_idx and hits; go to RUN; if count==0, go instead straight to IDLE and pulse done the next cycle.
REQ-022 Stall rule: pl_enable = (state != IDLE) && !(match_valid && !match_ready); tracking state advances only when pl_enable=1.
REQ-023 RUN, on each pl_enable cycle: pl_state = base + issue_idx (modulo 2^StateWidth, wrap allowed); issue_idx increments; the issue is marked valid.
REQ-024 RUN: after the issue with issue_idx == count-1, go to DRAIN.
REQ-025 DRAIN: pl_state = 0, and inserted entries are marked invalid (bubbles).
REQ-026 A valid-tag shift register of depth Latency SHALL advance on pl_enable only; its tail marks pl_keystream as valid.
REQ-027 Retire = pl_enable && tail valid; each retire increments retire_idx.
REQ-028 Hit = retire && ((pl_keystream ^ target) & mask) == 0.
REQ-029 On a hit, the following cycle: match_valid=1, match_state = base + retire_idx (the pre-increment value), hits += 1 (saturating at 2^32-1).
REQ-030 match_valid SHALL clear on match_valid && match_ready, unless a new hit loads in the same cycle; the new hit takes priority.
REQ-031 DRAIN with retire_idx == count and match_valid=0: go to IDLE and pulse done for one cycle.
REQ-032 Pipeline latency is Latency enabled cycles; stalled cycles do not count toward it.
REQ-033 start is ignored outside IDLE.
REQ-034 abort in RUN or DRAIN: go to IDLE; clear the tag register, match_valid and issue_idx; hits is kept; done is not pulsed. abort in IDLE has no effect.
REQ-035 abort and start in the same IDLE cycle: start wins.
REQ-036 mask = 0: every retired candidate is a hit.

Reset
REQ-037 rst_n=0 at a clock edge: state=IDLE; pl_enable=0; pl_state=0; match_valid=0; match_state=0; busy=0; done=0; hits=0; all tags invalid; all indices and captured registers 0.
REQ-038 Reset SHALL override start and abort and SHALL take effect mid-job with no done pulse.

Verification
REQ-039 Basic run: start, base=0x10, count=4, mask=0, match_ready=1 -> four matches with states 0x10..0x13, on cycles 101..104 after start; done pulses after the last match; hits=4.
REQ-040 Selective match: count=200, the pipeline model's keystream equals target only for candidate base+150 -> exactly one match, state base+150; hits=1.
REQ-041 Backpressure: mask=0, match_ready held low for 20 cycles -> pl_enable=0 and match_state stable during that time; after release, no loss or duplication, results in order.
REQ-042 Edge cases: count=0 -> done after 1 cycle and busy never set; base=0xFFFF_FFFF_FFFF_FFFE, count=3 -> states ...FE, ...FF, 0x0.
REQ-043 Abort mid-DRAIN (cycle 50), then a new start -> no done pulse and no stale matches from the first job; the second job completes correctly.
REQ-044 rst_n low during RUN -> all outputs at their reset values the next cycle; the following job behaves as after power-up.
